// File: rtl/stream_demux_pkg.sv
// Shared types and elaboration helpers for the stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  // True when a select of sel_w bits can address every one of num_ch channels.
  function automatic bit sel_w_fits(input int unsigned sel_w, input int unsigned num_ch);
    return (64'd1 << sel_w) >= 64'(num_ch);
  endfunction

  // Value at which a cnt_w-bit counter stops incrementing.
  function automatic logic [63:0] cnt_sat_val(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/stream_demux_oreg.sv
// One-entry output pipeline register: holds a beat and its channel until that
// channel's ready drains it; reloads in the same cycle it drains.
module stream_demux_oreg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [NUM_CH-1:0] m_ready,
  output logic              can_load_c,
  output logic              o_vld,
  output logic [NUM_CH-1:0] m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  logic [CH_W-1:0] o_ch;
  logic            drain;

  assign drain      = o_vld && m_ready[o_ch];
  assign can_load_c = !o_vld || m_ready[o_ch];

  // Payload and channel only change on load, so a stalled beat stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld  <= 1'b0;
      o_ch   <= '0;
      m_data <= '0;
      m_last <= 1'b0;
    end else if (load) begin
      o_vld  <= 1'b1;
      o_ch   <= load_ch;
      m_data <= load_data;
      m_last <= load_last;
    end else if (drain) begin
      o_vld  <= 1'b0;
    end
  end

  always_comb begin
    m_valid       = '0;
    m_valid[o_ch] = o_vld;
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH packet demultiplexer: locks the route per packet,
// discards and counts packets whose select is out of range.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic              s_last,
  output logic [NUM_CH-1:0] m_valid,
  input  logic [NUM_CH-1:0] m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned      CH_W    = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_val(CNT_W));

  if (!sel_w_fits(SEL_W, NUM_CH)) begin : g_bad_sel_w
    $error("stream_demux: SEL_W too narrow for NUM_CH");
  end

  state_t          state, state_nxt;
  logic [CH_W-1:0] lock_ch;
  logic [CH_W-1:0] load_ch;
  logic            s_ready_c;
  logic            accept;
  logic            load;
  logic            drop_inc;
  logic            sel_bad;
  logic            can_load_c;
  logic            o_vld;

  assign sel_bad = 32'(s_sel) >= NUM_CH;
  assign accept  = s_valid && s_ready_c;
  assign s_ready = s_ready_c;
  assign busy    = (state != IDLE) || o_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && !s_last) state_nxt = sel_bad ? DROP : PKT;
      PKT:     if (accept && s_last)  state_nxt = IDLE;
      DROP:    if (accept && s_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A bad select is swallowed even when the output register is full.
  always_comb begin
    s_ready_c = 1'b0;
    load      = 1'b0;
    drop_inc  = 1'b0;
    load_ch   = lock_ch;
    unique case (state)
      IDLE: begin
        s_ready_c = enable && (sel_bad || can_load_c);
        load      = s_valid && s_ready_c && !sel_bad;
        drop_inc  = s_valid && s_ready_c && sel_bad;
        load_ch   = CH_W'(s_sel);
      end
      PKT: begin
        s_ready_c = can_load_c;
        load      = s_valid && can_load_c;
      end
      DROP:    s_ready_c = 1'b1;
      default: s_ready_c = 1'b0;
    endcase
    if (!rst_n) begin
      s_ready_c = 1'b0;
      load      = 1'b0;
      drop_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_ch  <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == IDLE && load)          lock_ch  <= load_ch;
      if (drop_inc && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  stream_demux_oreg #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_oreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_ch    (load_ch),
    .load_data  (s_data),
    .load_last  (s_last),
    .m_ready    (m_ready),
    .can_load_c (can_load_c),
    .o_vld      (o_vld),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last)
  );

endmodule
